// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transmit FSM states, line-level constants and default sizing
// reused by both the transmit and receive byte paths.
package i2c_pkg;

   localparam int unsigned I2C_DATA_WIDTH = 8;
   localparam int unsigned I2C_CLK_DIV    = 4;

   // SDA level driven by the receiver during the 9th clock
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_ACK_LOW,
      ST_ACK_HIGH,
      ST_FINISH
   } i2c_tx_state_e;

   // Counter width for a range of n values; never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/register_piso_param.sv
// Parallel-in, serial-out shift register; the MSB is the serial output and
// zeros enter at the LSB on every shift.
module register_piso_param
   import i2c_pkg::*;
#(
   parameter int unsigned           reg_width   = I2C_DATA_WIDTH,
   parameter logic [reg_width-1:0]  reset_value = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift,
   input  logic                 clear,
   input  logic [reg_width-1:0] par_in,
   output logic                 ser_out
);

   logic [reg_width-1:0] shift_reg;

   // clear has priority over load, load over shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= reset_value;
      end else if (clear) begin
         shift_reg <= reset_value;
      end else if (load) begin
         shift_reg <= par_in;
      end else if (shift) begin
         shift_reg <= shift_reg << 1;
      end
   end

   assign ser_out = shift_reg[reg_width-1];

endmodule

// File: rtl/i2c_byte_tx.sv
// Master-side I2C byte transmitter: drives SCL, shifts a byte out MSB-first on SDA,
// then releases SDA for the 9th clock and samples the slave acknowledge.
module i2c_byte_tx
   import i2c_pkg::*;
#(
   parameter int unsigned data_width = I2C_DATA_WIDTH,
   parameter int unsigned clk_div    = I2C_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [data_width-1:0] tx_data,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  scl_oe,
   output logic                  sda_oe,
   output logic                  busy,
   output logic                  done,
   output logic                  ack
);

   localparam int unsigned   BIT_W    = cnt_width(data_width);
   localparam int unsigned   PH_W     = cnt_width(clk_div);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_width - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(clk_div - 1);

   i2c_tx_state_e    state;
   logic [BIT_W-1:0] bit_cnt;
   logic [PH_W-1:0]  phase;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_clear;
   logic             sr_msb;
   logic             scl_seen_high_c;
   logic             phase_last_c;

   // While our own registered drive is still pulling SCL low (first cycle of a high
   // phase) the low line is not a stretch; only a released-but-low line holds the count.
   assign scl_seen_high_c = scl_in | scl_oe;
   assign phase_last_c    = (phase == PH_LAST);

   assign sr_load  = (state == ST_IDLE) && start;
   assign sr_shift = (state == ST_HIGH) && scl_seen_high_c && phase_last_c;
   assign sr_clear = (state == ST_FINISH);

   register_piso_param #(
      .reg_width   (data_width),
      .reset_value ('0)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (sr_load),
      .shift   (sr_shift),
      .clear   (sr_clear),
      .par_in  (tx_data),
      .ser_out (sr_msb)
   );

   // Transfer sequencer; line controls are registered from the current state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         phase   <= '0;
         scl_oe  <= 1'b0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               scl_oe <= 1'b0;
               sda_oe <= 1'b0;
               busy   <= start;
               phase  <= '0;
               if (start) begin
                  ack     <= 1'b0;
                  bit_cnt <= BIT_LAST;
                  state   <= ST_LOW;
               end
            end

            ST_LOW: begin
               scl_oe <= 1'b1;
               sda_oe <= ~sr_msb;
               if (phase_last_c) begin
                  phase <= '0;
                  state <= ST_HIGH;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            ST_HIGH: begin
               scl_oe <= 1'b0;
               if (scl_seen_high_c) begin
                  if (phase_last_c) begin
                     phase   <= '0;
                     bit_cnt <= bit_cnt - BIT_W'(1);
                     state   <= (bit_cnt == '0) ? ST_ACK_LOW : ST_LOW;
                  end else begin
                     phase <= phase + PH_W'(1);
                  end
               end
            end

            ST_ACK_LOW: begin
               scl_oe <= 1'b1;
               sda_oe <= 1'b0;
               if (phase_last_c) begin
                  phase <= '0;
                  state <= ST_ACK_HIGH;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            ST_ACK_HIGH: begin
               scl_oe <= 1'b0;
               if (scl_seen_high_c) begin
                  if (phase_last_c) begin
                     ack   <= (sda_in == I2C_ACK);
                     phase <= '0;
                     state <= ST_FINISH;
                  end else begin
                     phase <= phase + PH_W'(1);
                  end
               end
            end

            ST_FINISH: begin
               scl_oe <= 1'b1;
               sda_oe <= 1'b0;
               done   <= 1'b1;
               state  <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
